imem_loader: RTL and testbench

- Write-side counterpart to the processor's instruction fetch path: the core only reads instruction memory; this block fills it.
- Receives a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and issues word writes to instruction memory.
- Holds the core in reset until a frame with a correct checksum has been fully loaded.

---
 rtl/imem_loader.sv | 167 ++++++++++++++++
 tb/tb_imem_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction memory loader: receives a length-prefixed, XOR-checksummed byte frame,
// packs little-endian words into imem writes and releases the core after a good load.
module imem_loader #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  byte_data,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        mem_write_enable,
   output logic [31:0] mem_adress,
   output logic [31:0] mem_write_data,
   output logic        core_run,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN0  = 3'd1,
      S_LEN1  = 3'd2,
      S_DATA  = 3'd3,
      S_CHECK = 3'd4,
      S_DONE  = 3'd5,
      S_ERROR = 3'd6
   } state_t;

   localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

   state_t        state_q, state_d;
   logic          byte_ready_q;
   logic          we_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic          core_run_q;
   logic          done_q;
   logic          error_q;
   logic [15:0]   len_q;
   logic [15:0]   word_cnt_q;
   logic [1:0]    idx_q;
   logic [23:0]   word_q;
   logic [7:0]    xor_q;

   logic          accept_s;
   logic          restart_s;
   logic [15:0]   len_d;
   logic [7:0]    xor_d;
   logic          len_big_s;
   logic          len_zero_s;
   logic          last_word_s;
   logic          sum_ok_s;

   // Handshake qualifiers and frame-level decisions derived from current state.
   always_comb begin
      accept_s    = byte_valid & byte_ready_q;
      restart_s   = start & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERROR));
      len_d       = {byte_data, len_q[7:0]};
      xor_d       = xor_q ^ byte_data;
      len_big_s   = ({1'b0, len_d} > DEPTH_L);
      len_zero_s  = (len_d == 16'd0);
      last_word_s = (word_cnt_q == (len_q - 16'd1));
      sum_ok_s    = (byte_data == xor_q);
   end

   // Next-state selection for the load sequence.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_LEN0; else state_d = state_q;
         S_LEN0:  if (accept_s) state_d = S_LEN1; else state_d = state_q;
         S_LEN1: begin
            if (!accept_s)      state_d = state_q;
            else if (len_big_s) state_d = S_ERROR;
            else if (len_zero_s) state_d = S_CHECK;
            else                state_d = S_DATA;
         end
         S_DATA: begin
            if (accept_s && (idx_q == 2'd3) && last_word_s) state_d = S_CHECK;
            else                                            state_d = state_q;
         end
         S_CHECK: begin
            if (!accept_s)     state_d = state_q;
            else if (sum_ok_s) state_d = S_DONE;
            else               state_d = S_ERROR;
         end
         S_DONE:  if (start) state_d = S_LEN0; else state_d = state_q;
         S_ERROR: if (start) state_d = S_LEN0; else state_d = state_q;
         default: state_d = S_IDLE;
      endcase
   end

   // State, datapath and registered outputs; outputs decode the state being entered.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         byte_ready_q <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         core_run_q   <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         len_q        <= 16'd0;
         word_cnt_q   <= 16'd0;
         idx_q        <= 2'd0;
         word_q       <= 24'd0;
         xor_q        <= 8'd0;
      end else begin
         state_q      <= state_d;
         byte_ready_q <= (state_d == S_LEN0) | (state_d == S_LEN1) |
                         (state_d == S_DATA) | (state_d == S_CHECK);
         done_q       <= (state_d == S_DONE);
         error_q      <= (state_d == S_ERROR);
         core_run_q   <= (state_d == S_DONE);
         we_q         <= 1'b0;
         if (restart_s) begin
            len_q      <= 16'd0;
            word_cnt_q <= 16'd0;
            idx_q      <= 2'd0;
            word_q     <= 24'd0;
            xor_q      <= 8'd0;
         end else if (accept_s) begin
            case (state_q)
               S_LEN0: begin
                  len_q[7:0] <= byte_data;
                  xor_q      <= xor_d;
               end
               S_LEN1: begin
                  len_q <= len_d;
                  xor_q <= xor_d;
               end
               S_DATA: begin
                  xor_q <= xor_d;
                  idx_q <= idx_q + 2'd1;
                  case (idx_q)
                     2'd0: word_q[7:0]   <= byte_data;
                     2'd1: word_q[15:8]  <= byte_data;
                     2'd2: word_q[23:16] <= byte_data;
                     default: begin
                        // Fourth byte completes the word: strobe it out next cycle.
                        we_q       <= 1'b1;
                        addr_q     <= BASE_ADDR + {14'd0, word_cnt_q, 2'b00};
                        wdata_q    <= {byte_data, word_q};
                        word_cnt_q <= word_cnt_q + 16'd1;
                     end
                  endcase
               end
               default: xor_q <= xor_q;
            endcase
         end else begin
            xor_q <= xor_q;
         end
      end
   end

   assign byte_ready       = byte_ready_q;
   assign mem_write_enable = we_q;
   assign mem_adress       = addr_q;
   assign mem_write_data   = wdata_q;
   assign core_run         = core_run_q;
   assign done             = done_q;
   assign error            = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as frames are driven
// and popped as write strobes appear.
module tb_imem_loader;

   logic        clock;
   logic        reset;
   logic        start;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        byte_ready;
   logic        mem_write_enable;
   logic [31:0] mem_adress;
   logic [31:0] mem_write_data;
   logic        core_run;
   logic        done;
   logic        error;

   int          n_cmp;
   int          n_err;
   int          cyc;
   int          last_cyc;
   bit          have_prev;
   bit          gap_chk;
   logic [63:0] exp_q[$];
   logic [31:0] wbuf [0:7];

   imem_loader #(.DEPTH_WORDS(4), .BASE_ADDR(32'h0000_0000)) dut (
      .clock            (clock),
      .reset            (reset),
      .start            (start),
      .byte_data        (byte_data),
      .byte_valid       (byte_valid),
      .byte_ready       (byte_ready),
      .mem_write_enable (mem_write_enable),
      .mem_adress       (mem_adress),
      .mem_write_data   (mem_write_data),
      .core_run         (core_run),
      .done             (done),
      .error            (error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Write-strobe monitor: every strobe must match the head of the scoreboard.
   always @(negedge clock) begin
      logic [63:0] e;
      cyc++;
      if (mem_write_enable === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_write", {32'd0, mem_adress}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check_val("wr_addr", {32'd0, mem_adress}, {32'd0, e[63:32]});
            check_val("wr_data", {32'd0, mem_write_data}, {32'd0, e[31:0]});
         end
         if (gap_chk && have_prev) check_val("strobe_gap", 64'(cyc - last_cyc), 64'd4);
         last_cyc  = cyc;
         have_prev = 1'b1;
      end
   end

   task automatic do_start();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gaps, input bit st);
      int bound;
      for (int g = 0; g < gaps; g++) begin
         byte_valid = 1'b0;
         byte_data  = 8'($urandom_range(0, 255));
         @(negedge clock);
      end
      byte_data  = b;
      byte_valid = 1'b1;
      start      = st;
      bound      = 0;
      while (byte_ready !== 1'b1 && bound < 50) begin
         @(negedge clock);
         bound++;
      end
      if (bound >= 50) check_val("ready_timeout", 64'd0, 64'd1);
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic send_frame(input int n, input bit bad, input bit stall, input bit start_mid);
      logic [7:0] cs;
      logic [7:0] b;
      logic [15:0] len;
      int bi;
      len = 16'(n);
      do_start();
      have_prev = 1'b0;
      gap_chk   = !stall;
      cs = len[7:0] ^ len[15:8];
      send_byte(len[7:0], 0, 1'b0);
      send_byte(len[15:8], stall ? $urandom_range(0, 2) : 0, 1'b0);
      bi = 0;
      for (int k = 0; k < n; k++) begin
         exp_q.push_back({32'(4 * k), wbuf[k]});
         for (int j = 0; j < 4; j++) begin
            b  = wbuf[k][8*j +: 8];
            cs = cs ^ b;
            send_byte(b, stall ? $urandom_range(0, 2) : 0, start_mid && (bi == 5));
            bi++;
         end
      end
      send_byte(bad ? (cs ^ 8'h01) : cs, stall ? $urandom_range(0, 2) : 0, 1'b0);
      byte_valid = 1'b0;
   endtask

   task automatic check_end(input bit exp_ok);
      check_val("done", {63'd0, done}, {63'd0, exp_ok});
      check_val("core_run", {63'd0, core_run}, {63'd0, exp_ok});
      check_val("error", {63'd0, error}, {63'd0, !exp_ok});
      check_val("ready_after", {63'd0, byte_ready}, 64'd0);
      check_val("sb_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_outs"},
                {57'd0, byte_ready, mem_write_enable, core_run, done, error, 2'b00},
                64'd0);
      check_val({tag, "_addr"}, {32'd0, mem_adress}, 64'd0);
      check_val({tag, "_data"}, {32'd0, mem_write_data}, 64'd0);
   endtask

   initial begin
      n_cmp = 0; n_err = 0; cyc = 0; last_cyc = 0;
      have_prev = 1'b0; gap_chk = 1'b0;
      reset = 1'b0; start = 1'b0; byte_data = 8'd0; byte_valid = 1'b0;
      repeat (3) @(negedge clock);
      check_all_zero("reset");
      reset = 1'b1;
      @(negedge clock);

      // Good two-word frame, valid held high.
      wbuf[0] = 32'h0050_0013;
      wbuf[1] = 32'h0010_0593;
      send_frame(2, 1'b0, 1'b0, 1'b0);
      check_end(1'b1);

      // Same frame with a corrupted checksum.
      send_frame(2, 1'b1, 1'b0, 1'b0);
      check_end(1'b0);

      // Oversize length is rejected immediately after the length bytes.
      do_start();
      have_prev = 1'b0;
      send_byte(8'h05, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      byte_valid = 1'b0;
      check_val("oversize_error", {63'd0, error}, 64'd1);
      check_val("oversize_ready", {63'd0, byte_ready}, 64'd0);
      check_val("oversize_run", {62'd0, core_run, done}, 64'd0);
      repeat (3) @(negedge clock);
      check_val("oversize_hold", {63'd0, error}, 64'd1);

      // Recovery with a one-word frame.
      wbuf[0] = 32'h1234_5678;
      send_frame(1, 1'b0, 1'b0, 1'b0);
      check_end(1'b1);

      // Full-depth frame: last write lands on the last word.
      wbuf[0] = 32'hDEAD_BEEF; wbuf[1] = 32'h0000_0001;
      wbuf[2] = 32'h8000_0000; wbuf[3] = 32'hA5C3_3C5A;
      send_frame(4, 1'b0, 1'b0, 1'b0);
      check_end(1'b1);

      // Zero-length frames.
      send_frame(0, 1'b0, 1'b0, 1'b0);
      check_end(1'b1);
      send_frame(0, 1'b1, 1'b0, 1'b0);
      check_end(1'b0);

      // Valid while idle is ignored, then a stalled frame with a stray start mid-data.
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      byte_data  = 8'hAA;
      byte_valid = 1'b1;
      repeat (3) @(negedge clock);
      check_val("idle_ready", {63'd0, byte_ready}, 64'd0);
      byte_valid = 1'b0;
      wbuf[0] = 32'h0050_0013;
      wbuf[1] = 32'h0010_0593;
      send_frame(2, 1'b0, 1'b1, 1'b1);
      check_end(1'b1);

      // Reset after five payload bytes abandons the frame.
      do_start();
      have_prev = 1'b0;
      gap_chk   = 1'b0;
      exp_q.push_back({32'd0, 32'h0050_0013});
      send_byte(8'h02, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h13, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h50, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h93, 0, 1'b0);
      reset      = 1'b0;
      byte_valid = 1'b0;
      @(negedge clock);
      check_all_zero("midreset");
      check_val("midreset_sb", 64'(exp_q.size()), 64'd0);
      @(negedge clock);
      reset = 1'b1;
      send_frame(2, 1'b0, 1'b0, 1'b0);
      check_end(1'b1);

      repeat (4) @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
